// File: rtl/spi_trace_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_trace_pkg: header layout, FSM encoding and header helpers    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package spi_trace_pkg;

  localparam int HDR_W         = 8;
  localparam int HDR_VALID_BIT = 7;
  localparam int HDR_OVF_BIT   = 6;
  localparam int HDR_LVL_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [HDR_W-1:0] make_header(input logic valid, input logic ovf,
                                                   input logic [31:0] lvl);
    logic [HDR_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_VALID_BIT] = valid;
    hdr[HDR_OVF_BIT]   = ovf;
    if (lvl > ((32'd1 << HDR_LVL_W) - 32'd1)) hdr[HDR_LVL_W-1:0] = '1;
    else hdr[HDR_LVL_W-1:0] = lvl[HDR_LVL_W-1:0];
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_trace_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_trace_fifo: power-of-two sample FIFO, push accepted when     |
// | full if a pop happens in the same cycle. Revision: 1.0           |
// +------------------------------------------------------------------+
module spi_trace_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{(LW-1){1'b0}}, do_push} - {{(LW-1){1'b0}}, do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_trace_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_trace_monitor: captures bus samples into a FIFO and streams  |
// | the head entry out as an SPI slave (mode 0). Revision: 1.0       |
// +------------------------------------------------------------------+
module spi_trace_monitor
  import spi_trace_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK_IN,
  input  logic                    RESET_N_IN,
  input  logic                    STROBE_IN,
  input  logic [ADDR_W-1:0]       ADDR_IN,
  input  logic [DATA_W-1:0]       DATA_IN,
  input  logic                    SPICLK_IN,
  input  logic                    SPISS_IN,
  output logic                    SPISO,
  output logic                    SPISO_OE,
  output logic [$clog2(DEPTH):0]  FIFO_LEVEL,
  output logic                    OVERFLOW
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int F       = HDR_W + ENTRY_W;
  localparam int CW      = $clog2(F + 1);
  localparam int LW      = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sck_prev;
  logic                   ss_prev;
  logic                   sck_s, ss_s;
  logic                   sck_rise, sck_fall, ss_rise, ss_fall;

  state_t                 state, state_next;
  logic [F-1:0]           shreg;
  logic [CW-1:0]          bit_cnt;
  logic                   snap_valid;
  logic                   snap_ovf;
  logic                   overflow;
  logic                   load, pop, overflow_clr, overflow_set;
  logic                   spiso_c, oe_c;

  logic [ENTRY_W-1:0]     fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [LW-1:0]          fifo_level;

  spi_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK_IN),
    .rst_n   (RESET_N_IN),
    .push    (STROBE_IN),
    .wr_data ({ADDR_IN, DATA_IN}),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Reset values represent an idle bus: deselected, clock low.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      sck_sync <= '0;
      ss_sync  <= '1;
      sck_prev <= 1'b0;
      ss_prev  <= 1'b1;
    end else begin
      sck_sync[0] <= SPICLK_IN;
      ss_sync[0]  <= SPISS_IN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i] <= sck_sync[i-1];
        ss_sync[i]  <= ss_sync[i-1];
      end
      sck_prev <= sck_s;
      ss_prev  <= ss_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s && !sck_prev;
  assign sck_fall = !sck_s && sck_prev;
  assign ss_rise  = ss_s && !ss_prev;
  assign ss_fall  = !ss_s && ss_prev;

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) state <= ST_IDLE;
    else             state <= state_next;
  end

  always_comb begin
    state_next   = state;
    load         = 1'b0;
    pop          = 1'b0;
    overflow_clr = 1'b0;
    spiso_c      = 1'b0;
    oe_c         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          state_next = ST_LOAD;
          load       = 1'b1;
        end
      end
      ST_LOAD: begin
        oe_c       = 1'b1;
        spiso_c    = shreg[F-1];
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        oe_c    = 1'b1;
        spiso_c = shreg[F-1];
        if (sck_rise && (bit_cnt == CW'(F - 1))) state_next = ST_DONE;
      end
      ST_DONE: begin
        oe_c = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
    // Only a fully clocked-out frame consumes its entry; aborted frames resend it.
    if (ss_rise && (state != ST_IDLE)) begin
      state_next = ST_IDLE;
      if ((state == ST_DONE) && snap_valid) begin
        pop          = 1'b1;
        overflow_clr = snap_ovf;
      end
    end
  end

  assign overflow_set = STROBE_IN && fifo_full && !pop;

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      snap_valid <= 1'b0;
      snap_ovf   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (overflow_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      if (load) begin
        shreg      <= {make_header(!fifo_empty, overflow, 32'(fifo_level)),
                       fifo_empty ? {ENTRY_W{1'b0}} : fifo_head};
        bit_cnt    <= '0;
        snap_valid <= !fifo_empty;
        snap_ovf   <= overflow;
      end else if (state == ST_SHIFT) begin
        if (sck_rise) bit_cnt <= bit_cnt + CW'(1);
        if (sck_fall) shreg <= {shreg[F-2:0], 1'b0};
      end
    end
  end

  assign SPISO      = spiso_c;
  assign SPISO_OE   = oe_c;
  assign FIFO_LEVEL = fifo_level;
  assign OVERFLOW   = overflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_trace_monitor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_trace_monitor: directed bench with FIFO scoreboard model  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_spi_trace_monitor;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int SYNC   = 2;
  localparam int F      = 8 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              strobe;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              sck;
  logic              ss;
  logic              spiso;
  logic              spiso_oe;
  logic [3:0]        level;
  logic              ovf;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic                     exp_ovf;
  logic [F-1:0]             got;

  always #5 clk = ~clk;

  spi_trace_monitor #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK_IN     (clk),
    .RESET_N_IN (rst_n),
    .STROBE_IN  (strobe),
    .ADDR_IN    (addr),
    .DATA_IN    (data),
    .SPICLK_IN  (sck),
    .SPISS_IN   (ss),
    .SPISO      (spiso),
    .SPISO_OE   (spiso_oe),
    .FIFO_LEVEL (level),
    .OVERFLOW   (ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    strobe = 1'b1;
    addr   = a;
    data   = d;
    if (exp_q.size() < DEPTH) exp_q.push_back({a, d});
    else exp_ovf = 1'b1;
    tick(1);
    strobe = 1'b0;
  endtask

  // Select, then clock nclk bits at 1/8 of the system clock, sampling before each rise.
  task automatic shift_frame(input int nclk);
    got = '0;
    ss  = 1'b0;
    tick(6);
    for (int i = 0; i < nclk; i++) begin
      tick(4);
      got = {got[F-2:0], spiso};
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic end_frame(input logic strobe_at_pop, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    ss = 1'b1;
    tick(SYNC);
    if (strobe_at_pop) begin
      strobe = 1'b1;
      addr   = a;
      data   = d;
    end
    tick(1);
    strobe = 1'b0;
    tick(3);
  endtask

  task automatic full_frame(input string tag, input logic strobe_at_pop,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic                     v;
    logic [7:0]               eh;
    logic [ADDR_W+DATA_W-1:0] ep;
    v  = (exp_q.size() != 0);
    eh = {v, exp_ovf, 6'(exp_q.size())};
    ep = v ? exp_q[0] : '0;
    shift_frame(F);
    tick(4);
    chk({tag, "_done_so"}, 64'(spiso), 64'd0);
    chk({tag, "_done_oe"}, 64'(spiso_oe), 64'd1);
    chk({tag, "_hdr"}, 64'(got[F-1:F-8]), 64'(eh));
    chk({tag, "_payload"}, 64'(got[F-9:0]), 64'(ep));
    if (v) begin
      void'(exp_q.pop_front());
      if (eh[6]) exp_ovf = 1'b0;
    end
    if (strobe_at_pop) exp_q.push_back({a, d});
    end_frame(strobe_at_pop, a, d);
    chk({tag, "_level"}, 64'(level), 64'(exp_q.size()));
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({tag, "_oe_off"}, 64'(spiso_oe), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    strobe  = 1'b0;
    addr    = '0;
    data    = '0;
    sck     = 1'b0;
    ss      = 1'b1;
    exp_ovf = 1'b0;
    tick(3);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_so", 64'(spiso), 64'd0);
    chk("rst_oe", 64'(spiso_oe), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Empty FIFO frame: all-zero, nothing popped.
    full_frame("empty", 1'b0, '0, '0);
    chk("empty_hdr_lit", 64'(got), 64'd0);

    // Three samples, first frame returns the oldest.
    do_strobe(24'h000100, 16'h1111);
    do_strobe(24'h000102, 16'h2222);
    do_strobe(24'h000104, 16'h3333);
    tick(1);
    chk("three_level", 64'(level), 64'd3);
    full_frame("f1", 1'b0, '0, '0);
    chk("f1_lit", 64'(got), 64'h83_000100_1111);
    full_frame("f2", 1'b0, '0, '0);
    full_frame("f3", 1'b0, '0, '0);

    // Overflow: nine samples into eight entries.
    for (int i = 0; i < 9; i++) do_strobe(24'h000200 + 24'(i), 16'hA000 + 16'(i));
    tick(1);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(ovf), 64'd1);
    full_frame("ovf", 1'b0, '0, '0);
    chk("ovf_hdr_lit", 64'(got[F-1:F-8]), 64'hC8);

    // Aborted frame leaves the entry in place.
    shift_frame(20);
    end_frame(1'b0, '0, '0);
    chk("abort_level", 64'(level), 64'd7);
    chk("abort_oe", 64'(spiso_oe), 64'd0);
    full_frame("resend", 1'b0, '0, '0);
    chk("resend_lit", 64'(got[F-9:0]), 64'h000201_A001);

    // Push coinciding with pop while full.
    do_strobe(24'h000300, 16'hB000);
    do_strobe(24'h000301, 16'hB001);
    tick(1);
    chk("refill_level", 64'(level), 64'd8);
    full_frame("popfull", 1'b1, 24'h000302, 16'hBEEF);
    chk("popfull_hdr_lit", 64'(got[F-1:F-8]), 64'h88);
    full_frame("after_popfull", 1'b0, '0, '0);

    // Asynchronous reset in the middle of a frame.
    shift_frame(30);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 64'(spiso_oe), 64'd0);
    chk("rst_mid_level", 64'(level), 64'd0);
    chk("rst_mid_so", 64'(spiso), 64'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    ss  = 1'b1;
    sck = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    full_frame("post_rst", 1'b0, '0, '0);
    chk("post_rst_hdr_lit", 64'(got[F-1:F-8]), 64'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_trace_monitor.md
SPI_TRACE_MONITOR -- requirements
Module: spi_trace_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, bus address width captured per sample.
REQ-002 SHALL have parameter DATA_W, default 16, bus data width captured per sample.
REQ-003 SHALL have parameter DEPTH, default 8, sample FIFO entries; power of two, 2..32.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on SPICLK_IN/SPISS_IN.
REQ-005 SHALL have port CLK_IN  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port RESET_N_IN  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port STROBE_IN  input  1  capture request, one sample per high cycle.
REQ-008 SHALL have port ADDR_IN  input  ADDR_W  bus address to capture.
REQ-009 SHALL have port DATA_IN  input  DATA_W  bus data to capture.
REQ-010 SHALL have port SPICLK_IN  input  1  asynchronous SPI clock, mode 0.
REQ-011 SHALL have port SPISS_IN  input  1  asynchronous SPI select, active-low.
REQ-012 SHALL have port SPISO  output  1  serial data out, MSB first.
REQ-013 SHALL have port SPISO_OE  output  1  output enable for external tristate; high only while selected.
REQ-014 SHALL have port FIFO_LEVEL  output  $clog2(DEPTH)+1  current FIFO entry count.
REQ-015 SHALL have port OVERFLOW  output  1  sticky sample-dropped flag.

Function
REQ-016 SHALL synchronise SPICLK_IN/SPISS_IN through SYNC_STAGES flops and edge-detect on the synchronised copies; CLK_IN frequency SHALL be at least 8x SPICLK_IN.
REQ-017 SHALL push {ADDR_IN, DATA_IN} on every cycle STROBE_IN=1 and FIFO not full; FIFO_LEVEL updates the following cycle.
REQ-018 SHALL, on push while full with no pop in the same cycle, drop the sample, keep contents unchanged and set OVERFLOW.
REQ-019 SHALL, on simultaneous push and pop while full, accept both; level unchanged, no overflow.
REQ-020 SHALL define frame length F = 8 + ADDR_W + DATA_W (48 by default).
REQ-021 SHALL use frame = header[7:0] then ADDR then DATA; header = {VALID, OVERFLOW, LEVEL saturated to 6 bits}.
REQ-022 SHALL set header VALID to 1 if FIFO non-empty at load; if empty, address/data bits are 0.
REQ-023 SHALL use FSM IDLE, LOAD, SHIFT, DONE.
REQ-024 SHALL, in IDLE on synchronised SS falling edge, go to LOAD for one cycle: snapshot head entry and header into the shift register, drive SPISO=MSB, assert SPISO_OE.
REQ-025 SHALL go LOAD -> SHIFT; in SHIFT, count each synchronised SCK rising edge and shift to the next bit on each SCK falling edge, within SYNC_STAGES+1 CLK_IN cycles of that edge.
REQ-026 SHALL go SHIFT -> DONE after F rising edges; in DONE, SPISO=0 for any further clocks.
REQ-027 SHALL, on synchronised SS rising edge from DONE with VALID=1, pop one entry and clear OVERFLOW if the frame reported OVERFLOW=1; a new overflow in the same cycle wins.
REQ-028 SHALL, on SS rising edge from LOAD or SHIFT (aborted frame), not pop and not clear OVERFLOW; the entry is re-sent next frame.
REQ-029 SHALL return every state to IDLE on SS rise with SPISO_OE=0 and SPISO=0.
REQ-030 SHALL keep STROBE_IN capture fully active during SPI frames; the snapshot is unaffected by later pushes.

Reset
REQ-031 SHALL, with RESET_N_IN low, immediately force FSM=IDLE, FIFO empty, FIFO_LEVEL=0, OVERFLOW=0, SPISO=0, SPISO_OE=0, bit counter=0 and synchronisers to idle (SS=1, SCK=0).
REQ-032 SHALL, on reset mid-frame, abort the frame and require a fresh SS falling edge after release.

Structure
REQ-033 SHALL place header field positions, header width (8) and FSM state encoding in shared package spi_trace_pkg.
REQ-034 SHALL implement the FIFO as sub-module spi_trace_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, level).

Verification
REQ-035 SHALL test: 3 strobes (0x000100/0x1111, 0x000102/0x2222, 0x000104/0x3333), one 48-clock frame -> header 0x83, then 0x0001001111; level 3 -> 2.
REQ-036 SHALL test: empty FIFO, 48-clock frame -> header 0x00, all zero bits, no pop, level stays 0.
REQ-037 SHALL test: 9 strobes with DEPTH=8 -> OVERFLOW=1, level 8; a complete frame shows header 0xC8 and clears OVERFLOW; level 7.
REQ-038 SHALL test: SS released after 20 clocks -> no pop; the next full frame returns the same entry.
REQ-039 SHALL test: strobe on the exact cycle of pop when full -> level stays 8, OVERFLOW stays 0.
REQ-040 SHALL test: RESET_N_IN low at bit 30 -> SPISO_OE=0 asynchronously, level 0; after release, a frame shows header 0x00.
